// File: rtl/bullet_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_scheduler_pkg
//  Description : Shared types and constants for the bullet scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package bullet_scheduler_pkg;

    localparam int c_COORD_W = 10;
    localparam int c_CD_W    = 5;

    localparam logic c_RIGHT  = 1'b0;
    localparam logic c_LEFT   = 1'b1;
    localparam logic c_PLAYER = 1'b0;
    localparam logic c_ENEMY  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_ARB  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [c_COORD_W-1:0] x;
        logic [c_COORD_W-1:0] y;
        logic                 dir;
        logic                 owner;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/bullet_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_scheduler_if
//  Description : Spawn requests, frame tick and per-slot bullet state bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bullet_scheduler_if
    import bullet_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = 4
);
    logic                                 frame_tick;
    logic                                 player_fire_req;
    logic [c_COORD_W-1:0]                 player_x;
    logic [c_COORD_W-1:0]                 player_y;
    logic                                 player_dir;
    logic                                 enemy_fire_req;
    logic [c_COORD_W-1:0]                 enemy_x;
    logic [c_COORD_W-1:0]                 enemy_y;
    logic                                 enemy_dir;
    logic [NUM_SLOTS-1:0]                 bullet_valid;
    logic [NUM_SLOTS-1:0][c_COORD_W-1:0]  bullet_x;
    logic [NUM_SLOTS-1:0][c_COORD_W-1:0]  bullet_y;
    logic [NUM_SLOTS-1:0]                 bullet_dir;
    logic [NUM_SLOTS-1:0]                 bullet_owner;
    logic                                 player_grant;
    logic                                 enemy_grant;
    logic                                 busy;

    modport master (
        output frame_tick, player_fire_req, player_x, player_y, player_dir,
               enemy_fire_req, enemy_x, enemy_y, enemy_dir,
        input  bullet_valid, bullet_x, bullet_y, bullet_dir, bullet_owner,
               player_grant, enemy_grant, busy
    );

    modport slave (
        input  frame_tick, player_fire_req, player_x, player_y, player_dir,
               enemy_fire_req, enemy_x, enemy_y, enemy_dir,
        output bullet_valid, bullet_x, bullet_y, bullet_dir, bullet_owner,
               player_grant, enemy_grant, busy
    );
endinterface
`default_nettype wire

// File: rtl/bullet_slot_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_slot_alloc
//  Description : Combinational lowest-index free slot priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_slot_alloc #(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_SLOTS-1:0] valid_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_free_o
);

    // Scan high to low so the last hit, the lowest free index, wins.
    always_comb begin
        idx_o      = '0;
        any_free_o = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                idx_o      = IDX_W'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bullet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_scheduler
//  Description : Per-frame bullet mover and player/enemy spawn arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_scheduler
    import bullet_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int BULLET_STEP     = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int X_MAX           = 639
) (
    input  logic                clk,
    input  logic                rst_n,
    bullet_scheduler_if.slave   sched_if
);

    localparam int                    IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [c_COORD_W:0]    c_STEP_EXT = (c_COORD_W + 1)'(BULLET_STEP);
    localparam logic [c_COORD_W:0]    c_XMAX_EXT = (c_COORD_W + 1)'(X_MAX);
    localparam logic [c_CD_W-1:0]     c_CD_LOAD  = c_CD_W'(COOLDOWN_FRAMES);
    localparam logic [c_CD_W-1:0]     c_CD_ONE   = c_CD_W'(1);

    state_t                   state_q;
    slot_t [NUM_SLOTS-1:0]    slots_q;
    slot_t [NUM_SLOTS-1:0]    slots_d;
    logic  [c_CD_W-1:0]       cooldown_q;
    logic                     rr_q;
    logic                     player_grant_q;
    logic                     enemy_grant_q;
    logic                     busy_q;

    logic [NUM_SLOTS-1:0]     w_valid;
    logic [IDX_W-1:0]         w_free_idx;
    logic                     w_any_free;
    logic                     w_player_elig;
    logic                     w_enemy_elig;
    logic                     w_grant;
    logic                     w_player_wins;
    slot_t                    w_new_slot;

    // Position update applied in MOVE; edge-crossing bullets retire in place.
    always_comb begin
        slots_d = slots_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slots_q[i].valid) begin
                if (slots_q[i].dir == c_LEFT) begin
                    if ({1'b0, slots_q[i].x} < c_STEP_EXT) begin
                        slots_d[i].valid = 1'b0;
                    end else begin
                        slots_d[i].x = slots_q[i].x - c_STEP_EXT[c_COORD_W-1:0];
                    end
                end else if (({1'b0, slots_q[i].x} + c_STEP_EXT) > c_XMAX_EXT) begin
                    slots_d[i].valid = 1'b0;
                end else begin
                    slots_d[i].x = slots_q[i].x + c_STEP_EXT[c_COORD_W-1:0];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_valid
        assign w_valid[i] = slots_q[i].valid;
    end

    bullet_slot_alloc #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_alloc (
        .valid_i    (w_valid),
        .idx_o      (w_free_idx),
        .any_free_o (w_any_free)
    );

    assign w_player_elig = sched_if.player_fire_req && (cooldown_q == '0);
    assign w_enemy_elig  = sched_if.enemy_fire_req;
    assign w_grant       = (w_player_elig || w_enemy_elig) && w_any_free;
    assign w_player_wins = w_player_elig && (!w_enemy_elig || (rr_q == c_PLAYER));

    always_comb begin
        w_new_slot.valid = 1'b1;
        w_new_slot.x     = w_player_wins ? sched_if.player_x   : sched_if.enemy_x;
        w_new_slot.y     = w_player_wins ? sched_if.player_y   : sched_if.enemy_y;
        w_new_slot.dir   = w_player_wins ? sched_if.player_dir : sched_if.enemy_dir;
        w_new_slot.owner = w_player_wins ? c_PLAYER            : c_ENEMY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            slots_q        <= '0;
            cooldown_q     <= '0;
            rr_q           <= c_PLAYER;
            player_grant_q <= 1'b0;
            enemy_grant_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            player_grant_q <= 1'b0;
            enemy_grant_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (sched_if.frame_tick) begin
                        state_q <= ST_MOVE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    slots_q <= slots_d;
                    state_q <= ST_ARB;
                end
                ST_ARB: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (w_grant) begin
                        slots_q[w_free_idx] <= w_new_slot;
                        player_grant_q      <= w_player_wins;
                        enemy_grant_q       <= !w_player_wins;
                        if (w_player_elig && w_enemy_elig) begin
                            rr_q <= ~rr_q;
                        end
                    end
                    // Decrement after the eligibility check so the lockout spans full frames.
                    if (w_grant && w_player_wins) begin
                        cooldown_q <= c_CD_LOAD;
                    end else if (cooldown_q != '0) begin
                        cooldown_q <= cooldown_q - c_CD_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_out
        assign sched_if.bullet_valid[i] = slots_q[i].valid;
        assign sched_if.bullet_x[i]     = slots_q[i].x;
        assign sched_if.bullet_y[i]     = slots_q[i].y;
        assign sched_if.bullet_dir[i]   = slots_q[i].dir;
        assign sched_if.bullet_owner[i] = slots_q[i].owner;
    end

    assign sched_if.player_grant = player_grant_q;
    assign sched_if.enemy_grant  = enemy_grant_q;
    assign sched_if.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bullet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bullet_scheduler
//  Description : Directed table, corner sequences and random frames vs. model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bullet_scheduler;

    localparam int NS   = 4;
    localparam int STEP = 4;
    localparam int CDF  = 8;
    localparam int XMAX = 639;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bullet_scheduler_if #(.NUM_SLOTS(NS)) bus  ();
    bullet_scheduler_if #(.NUM_SLOTS(NS)) bus0 ();

    // Second instance with no cooldown shares all stimulus.
    assign bus0.frame_tick      = bus.frame_tick;
    assign bus0.player_fire_req = bus.player_fire_req;
    assign bus0.player_x        = bus.player_x;
    assign bus0.player_y        = bus.player_y;
    assign bus0.player_dir      = bus.player_dir;
    assign bus0.enemy_fire_req  = bus.enemy_fire_req;
    assign bus0.enemy_x         = bus.enemy_x;
    assign bus0.enemy_y         = bus.enemy_y;
    assign bus0.enemy_dir       = bus.enemy_dir;

    bullet_scheduler #(.NUM_SLOTS(NS), .BULLET_STEP(STEP), .COOLDOWN_FRAMES(CDF), .X_MAX(XMAX))
        u_dut (.clk(clk), .rst_n(rst_n), .sched_if(bus));
    bullet_scheduler #(.NUM_SLOTS(NS), .BULLET_STEP(STEP), .COOLDOWN_FRAMES(0), .X_MAX(XMAX))
        u_dut0 (.clk(clk), .rst_n(rst_n), .sched_if(bus0));

    int m_valid [NS];
    int m_x     [NS];
    int m_y     [NS];
    int m_dir   [NS];
    int m_own   [NS];
    int m_cd;
    int m_rr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit p_req; int p_x; int p_y; bit p_dir;
        bit e_req; int e_x; int e_y; bit e_dir;
        bit exp_pg; bit exp_eg;
        int chk_slot; bit exp_valid; int exp_x;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_own[i] = 0;
        end
        m_cd = 0;
        m_rr = 0;
    endtask

    task automatic model_frame(input bit pr, input int px, input int py, input bit pd,
                               input bit er, input int ex, input int ey, input bit ed,
                               output bit epg, output bit eeg);
        int  fr;
        bit  pe;
        bit  pw;
        for (int i = 0; i < NS; i++) begin
            if (m_valid[i] != 0) begin
                if (m_dir[i] == 1) begin
                    if (m_x[i] < STEP) m_valid[i] = 0;
                    else               m_x[i] = m_x[i] - STEP;
                end else begin
                    if (m_x[i] + STEP > XMAX) m_valid[i] = 0;
                    else                      m_x[i] = m_x[i] + STEP;
                end
            end
        end
        pe  = pr && (m_cd == 0);
        fr  = -1;
        epg = 0;
        eeg = 0;
        for (int i = NS - 1; i >= 0; i--) if (m_valid[i] == 0) fr = i;
        if (fr >= 0 && (pe || er)) begin
            pw = pe && (!er || m_rr == 0);
            m_valid[fr] = 1;
            m_x[fr]   = pw ? px : ex;
            m_y[fr]   = pw ? py : ey;
            m_dir[fr] = pw ? int'(pd) : int'(ed);
            m_own[fr] = pw ? 0 : 1;
            if (pe && er) m_rr = 1 - m_rr;
            epg = pw;
            eeg = !pw;
        end
        if (epg)           m_cd = CDF;
        else if (m_cd > 0) m_cd = m_cd - 1;
    endtask

    task automatic check_slots(input string tag);
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("%s slot%0d valid", tag, i), 32'(bus.bullet_valid[i]), m_valid[i]);
            if (m_valid[i] != 0) begin
                chk($sformatf("%s slot%0d x", tag, i),     32'(bus.bullet_x[i]),     m_x[i]);
                chk($sformatf("%s slot%0d y", tag, i),     32'(bus.bullet_y[i]),     m_y[i]);
                chk($sformatf("%s slot%0d dir", tag, i),   32'(bus.bullet_dir[i]),   m_dir[i]);
                chk($sformatf("%s slot%0d owner", tag, i), 32'(bus.bullet_owner[i]), m_own[i]);
            end
        end
    endtask

    // One frame: tick held for 'hold' cycles (extra cycles land in MOVE/ARB and are ignored).
    task automatic do_frame(input bit pr, input int px, input int py, input bit pd,
                            input bit er, input int ex, input int ey, input bit ed,
                            input int hold, output bit gp, output bit ge,
                            output bit g0p, output bit g0e);
        bit epg, eeg;
        model_frame(pr, px, py, pd, er, ex, ey, ed, epg, eeg);
        @(negedge clk);
        bus.player_fire_req = pr; bus.player_x = 10'(px); bus.player_y = 10'(py); bus.player_dir = pd;
        bus.enemy_fire_req  = er; bus.enemy_x  = 10'(ex); bus.enemy_y  = 10'(ey); bus.enemy_dir  = ed;
        bus.frame_tick = 1'b1;
        gp = 0; ge = 0; g0p = 0; g0e = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                gp  = bus.player_grant;  ge  = bus.enemy_grant;
                g0p = bus0.player_grant; g0e = bus0.enemy_grant;
                chk("player_grant", 32'(gp), 32'(epg));
                chk("enemy_grant", 32'(ge), 32'(eeg));
                chk("busy after ARB", 32'(bus.busy), 0);
            end else begin
                chk($sformatf("grants quiet c%0d", c), 32'({bus.player_grant, bus.enemy_grant}), 0);
                chk($sformatf("busy c%0d", c), 32'(bus.busy), 32'(c < 3));
            end
            if (c == hold) bus.frame_tick = 1'b0;
        end
        check_slots("frame");
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst valid", 32'(bus.bullet_valid), 0);
        chk("rst pos",   32'(|{bus.bullet_x, bus.bullet_y}), 0);
        chk("rst dir/owner", 32'(|{bus.bullet_dir, bus.bullet_owner}), 0);
        chk("rst grants/busy", 32'({bus.player_grant, bus.enemy_grant, bus.busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic int rand_x();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 7));
            1:       return int'($urandom_range(630, 639));
            default: return int'($urandom_range(0, 639));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bit gp, ge, g0p, g0e;
        bit exp0p [5];
        bit exp0e [5];
        bus.frame_tick = 0; bus.player_fire_req = 0; bus.player_x = 0; bus.player_y = 0;
        bus.player_dir = 0; bus.enemy_fire_req = 0; bus.enemy_x = 0; bus.enemy_y = 0; bus.enemy_dir = 0;
        model_reset();
        apply_reset();

        vt[0]  = '{1, 100, 200, 0,  0,   0,  0, 0,  1, 0,  0, 1, 100};
        vt[1]  = '{0,   0,   0, 0,  0,   0,  0, 0,  0, 0,  0, 1, 104};
        vt[2]  = '{0,   0,   0, 0,  1, 300, 50, 1,  0, 1,  1, 1, 300};
        vt[3]  = '{1,   7,   7, 0,  1,   4, 10, 1,  0, 1,  2, 1,   4};
        vt[4]  = '{0,   0,   0, 0,  0,   0,  0, 0,  0, 0,  2, 1,   0};
        vt[5]  = '{0,   0,   0, 0,  0,   0,  0, 0,  0, 0,  2, 0,   0};
        vt[6]  = '{0,   0,   0, 0,  1,   3, 20, 1,  0, 1,  2, 1,   3};
        vt[7]  = '{0,   0,   0, 0,  0,   0,  0, 0,  0, 0,  2, 0,   0};
        vt[8]  = '{1,  50,  60, 0,  0,   0,  0, 0,  0, 0,  0, 1, 132};
        vt[9]  = '{1,  50,  60, 0,  1, 500,  1, 0,  1, 0,  2, 1,  50};
        vt[10] = '{0,   0,   0, 0,  1, 500,  1, 0,  0, 1,  3, 1, 500};
        vt[11] = '{0,   0,   0, 0,  1, 500,  1, 0,  0, 0,  3, 1, 504};
        for (int i = 0; i < 12; i++) begin
            do_frame(vt[i].p_req, vt[i].p_x, vt[i].p_y, vt[i].p_dir,
                     vt[i].e_req, vt[i].e_x, vt[i].e_y, vt[i].e_dir,
                     1 + (i % 3), gp, ge, g0p, g0e);
            chk($sformatf("vec%0d pg", i), 32'(gp), 32'(vt[i].exp_pg));
            chk($sformatf("vec%0d eg", i), 32'(ge), 32'(vt[i].exp_eg));
            chk($sformatf("vec%0d valid", i), 32'(bus.bullet_valid[vt[i].chk_slot]), 32'(vt[i].exp_valid));
            if (vt[i].exp_valid)
                chk($sformatf("vec%0d x", i), 32'(bus.bullet_x[vt[i].chk_slot]), vt[i].exp_x);
        end

        for (int f = 0; f < 80; f++) begin
            bit pr, pd, er, ed;
            int px, py, ex, ey;
            pr = 1'($urandom_range(0, 1)); pd = 1'($urandom_range(0, 1));
            er = 1'($urandom_range(0, 1)); ed = 1'($urandom_range(0, 1));
            px = rand_x(); py = int'($urandom_range(0, 1023));
            ex = rand_x(); ey = int'($urandom_range(0, 1023));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_frame(pr, px, py, pd, er, ex, ey, ed, int'($urandom_range(1, 3)), gp, ge, g0p, g0e);
        end

        // Slot 0 reaches x=638 with every slot full; it retires and is reused the same frame.
        apply_reset();
        do_frame(1, 626, 5, 0, 0, 0, 0, 0, 1, gp, ge, g0p, g0e);
        for (int f = 0; f < 3; f++) do_frame(0, 0, 0, 0, 1, 10, 10, 0, 1, gp, ge, g0p, g0e);
        chk("edge slot0 x", 32'(bus.bullet_x[0]), 638);
        chk("edge all full", 32'(bus.bullet_valid), 32'hF);
        do_frame(0, 0, 0, 0, 1, 200, 300, 1, 1, gp, ge, g0p, g0e);
        chk("edge reuse eg", 32'(ge), 1);
        chk("edge reuse owner", 32'(bus.bullet_owner[0]), 1);
        chk("edge reuse x", 32'(bus.bullet_x[0]), 200);

        // Reset in ARB with a pending request cancels the grant.
        apply_reset();
        @(negedge clk);
        bus.player_fire_req = 1; bus.enemy_fire_req = 0;
        bus.player_x = 10; bus.player_y = 10; bus.player_dir = 0;
        bus.frame_tick = 1;
        @(negedge clk);
        bus.frame_tick = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort valid", 32'(bus.bullet_valid), 0);
        @(negedge clk);
        chk("abort no grant", 32'({bus.player_grant, bus.enemy_grant}), 0);
        chk("abort valid held", 32'(bus.bullet_valid), 0);
        rst_n = 1'b1;
        model_reset();
        do_frame(1, 10, 10, 0, 0, 0, 0, 0, 1, gp, ge, g0p, g0e);
        chk("post-reset grant", 32'(gp), 1);

        // Player held: cooldown of 8 frames allows grants on frames 1 and 10 only.
        apply_reset();
        for (int f = 1; f <= 11; f++) begin
            do_frame(1, 20, 20, 0, 0, 0, 0, 0, 1, gp, ge, g0p, g0e);
            chk($sformatf("cooldown frame%0d", f), 32'(gp), 32'(f == 1 || f == 10));
        end

        // No-cooldown instance: contested grants alternate, then slots run out.
        apply_reset();
        exp0p = '{1, 0, 1, 0, 0};
        exp0e = '{0, 1, 0, 1, 0};
        for (int f = 0; f < 5; f++) begin
            do_frame(1, 40, 40, 0, 1, 60, 60, 1, 1, gp, ge, g0p, g0e);
            chk($sformatf("rr frame%0d pg", f + 1), 32'(g0p), 32'(exp0p[f]));
            chk($sformatf("rr frame%0d eg", f + 1), 32'(g0e), 32'(exp0e[f]));
        end
        chk("rr valid", 32'(bus0.bullet_valid), 32'hF);
        chk("rr owners", 32'(bus0.bullet_owner), 32'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bullet_scheduler.md
BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_SLOTS, default 4, bullet slot count; BULLET_STEP, default 4, pixels moved per frame; COOLDOWN_FRAMES, default 8, frames of player refire lockout; X_MAX, default 639, rightmost on-screen pixel.
REQ-002 Clk  in  1  system clock; the only clock.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 frame_tick  in  1  one-Clk pulse per video frame, synchronous to Clk.
REQ-005 player_fire_req  in  1  level; player requests a bullet.
REQ-006 player_x, player_y  in  10 each  player spawn position.
REQ-007 player_dir  in  1  player spawn direction; 0 is right, 1 is left.
REQ-008 enemy_fire_req  in  1  level; enemy requests a bullet.
REQ-009 enemy_x, enemy_y  in  10 each  enemy spawn position.
REQ-010 enemy_dir  in  1  enemy spawn direction; 0 is right, 1 is left.
REQ-011 bullet_valid  out  NUM_SLOTS  per-slot active flag.
REQ-012 bullet_x, bullet_y  out  NUM_SLOTS x 10  per-slot position.
REQ-013 bullet_dir, bullet_owner  out  NUM_SLOTS each  per-slot direction; owner is 0 for player, 1 for enemy.
REQ-014 player_grant, enemy_grant  out  1 each  one-cycle pulse; the request was accepted.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states, IDLE, MOVE and ARB, with one cycle in each of MOVE and ARB.
REQ-017 frame_tick in IDLE SHALL move the FSM to MOVE; frame_tick in MOVE or ARB SHALL be ignored.
REQ-018 In MOVE, each valid slot SHALL advance BULLET_STEP: add for dir=0, subtract for dir=1, unsigned 10-bit arithmetic.
REQ-019 In MOVE, a slot with dir=1 and x < BULLET_STEP SHALL clear its valid bit instead of moving.
REQ-020 In MOVE, a slot with dir=0 and x + BULLET_STEP > X_MAX SHALL clear its valid bit instead of moving.
REQ-021 MOVE SHALL then go to ARB; ARB SHALL then go to IDLE.
REQ-022 In ARB, requests SHALL be sampled.
REQ-023 The player SHALL be eligible in ARB only while the cooldown counter is 0.
REQ-024 At most one grant SHALL be issued per frame.
REQ-025 With both requesters eligible, the grant SHALL follow a round-robin pointer, and the pointer SHALL toggle only after such a contested grant.
REQ-026 The pointer SHALL reset to favour the player.
REQ-027 A grant SHALL allocate the lowest-index free slot, loading x, y, dir and owner from the winner's inputs and setting valid.
REQ-028 A slot freed in MOVE SHALL be allocatable in the same frame's ARB.
REQ-029 A slot allocated in ARB SHALL not move until the next frame.
REQ-030 With no free slot, no grant SHALL be issued and the request SHALL be dropped, not queued.
REQ-031 The grant pulse and slot contents SHALL be registered at the end of ARB and visible in the following cycle.
REQ-032 Latency SHALL be: frame_tick at cycle T, MOVE at T+1, ARB at T+2, grant high at T+3 only.
REQ-033 On a player grant, the cooldown counter SHALL load COOLDOWN_FRAMES.
REQ-034 On every accepted frame_tick, the cooldown counter SHALL decrement, saturating at 0.
REQ-035 The cooldown counter SHALL be 5 bits wide.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 Reset low SHALL immediately force: FSM to IDLE; all bullet_valid, grants and busy to 0; positions, dir and owner to 0; cooldown to 0; round-robin pointer to player.
REQ-038 Reset mid-MOVE or mid-ARB SHALL abort that frame; the first frame_tick after reset release SHALL run normally.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, owner and direction constants (RIGHT=0, LEFT=1, PLAYER=0, ENEMY=1) and a bullet slot struct (valid, x, y, dir, owner).
REQ-040 One sub-module, bullet_slot_alloc, SHALL hold the combinational lowest-free-slot priority encoder: NUM_SLOTS-bit valid in, index and any_free out.

Verification
REQ-041 Reset, player_fire_req=1 at (100,200) dir=0, frame_tick at T -> player_grant high at T+3 only; slot0 valid at (100,200); next frame_tick -> slot0 x=104.
REQ-042 Both requests held across 4 frames, cooldown irrelevant with COOLDOWN_FRAMES=0 -> grants alternate player, enemy, player, enemy; slots 0..3 filled; fifth frame -> no grant.
REQ-043 Player held high, COOLDOWN_FRAMES=8 -> grants on frame 1 and frame 10 only.
REQ-044 Slot0 at x=638 dir=0, all slots full, enemy requesting -> slot0 retires in MOVE; enemy granted into slot0 in the same ARB.
REQ-045 Slot at x=3 dir=1 -> retired on next frame; slot at x=4 dir=1 -> x=0, retired the frame after.
REQ-046 Reset asserted at T+2 (ARB) with a request pending -> no grant; all outputs 0; a frame_tick after release -> grant at +3.
